// File: rtl/vga_pkg.sv
// Shared timing constants, widths and helpers for the VGA display-timing stage.
// The defaults describe standard 640x480@60 with active-low sync pulses.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_POL_DEF = 1'b0;

  // Half-open window test: lo <= cnt < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/pix_div.sv
// Pixel-enable divider: a one-clk pix_en pulse every CLK_DIV system clocks.
// tick_next is high on the clk just before pix_en, so callers can register events that line up with it.
module pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic tick_next
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;

  always_comb begin
    tick_next = (div_q == DIV_LAST);
    div_d     = tick_next ? '0 : div_q + 1'b1;
    pix_en_d  = tick_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing.sv
// VGA display timing: pixel counters for the renderer, plus sync and blanked colour
// output delayed one pixel tick so they line up with the renderer's returned rgb.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic               pix_en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               active,
  output logic               frame_start,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic tick, tick_next;

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               active_q, active_d;
  logic               frame_start_q, frame_start_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;

  pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    active_d = active_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;

    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      active_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      // The rgb arriving now belongs to the pixel still shown on col/row, so blank with that pixel's active.
      rgb_d = active_q ? rgb_in : '0;
      hs_d  = in_window(h_cnt_q, HS_START, HS_END) ~^ SYNC_POL;
      vs_d  = in_window(v_cnt_q, VS_START, VS_END) ~^ SYNC_POL;
    end

    // Look at the counter value that will be on display during the next pix_en, which also covers CLK_DIV = 1.
    frame_start_d = tick_next && (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_q      <= 1'b1;
      frame_start_q <= 1'b0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      rgb_q         <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
    end
  end

  assign pix_en      = tick;
  assign col         = h_cnt_q;
  assign row         = v_cnt_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a shrunken 15x8 raster (CLK_DIV = 4), plus a CLK_DIV = 1 instance.
// Expected coordinates, sync, blanking and frame timing are derived from the pixel tick index.
module tb_vga_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] rgbIn = 12'h000;
  logic [11:0] rgbIn1 = 12'h000;

  logic       pixEn, active, frameStart, vgaHs, vgaVs;
  logic [9:0] col, row;
  logic [3:0] vgaR, vgaG, vgaB;

  logic       pixEn1, active1, frameStart1, vgaHs1, vgaVs1;
  logic [9:0] col1, row1;
  logic [3:0] vgaR1, vgaG1, vgaB1;

  int cycleCount = 0;
  int compareCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  vga_timing #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgbIn), .pix_en(pixEn), .col(col), .row(row),
    .active(active), .frame_start(frameStart), .vga_hs(vgaHs), .vga_vs(vgaVs),
    .vga_r(vgaR), .vga_g(vgaG), .vga_b(vgaB)
  );

  vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .rgb_in(rgbIn1), .pix_en(pixEn1), .col(col1), .row(row1),
    .active(active1), .frame_start(frameStart1), .vga_hs(vgaHs1), .vga_vs(vgaVs1),
    .vga_r(vgaR1), .vga_g(vgaG1), .vga_b(vgaB1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Drive rgb for pixel position p: all-white, or a col/row tag so alignment slips are visible.
  task automatic applyStimulus(input int p, input bit alignMode);
    logic [3:0] hN, vN;
    hN = 4'((p % FRAME) % HT);
    vN = 4'((p % FRAME) / HT);
    if (!alignMode && p < FRAME) rgbIn = 12'hFFF;
    else rgbIn = {hN, vN, 4'h0};
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_col"}, 32'(col), 32'd0);
    checkOutput({pfx, "_row"}, 32'(row), 32'd0);
    checkOutput({pfx, "_active"}, 32'(active), 32'd1);
    checkOutput({pfx, "_pix_en"}, 32'(pixEn), 32'd0);
    checkOutput({pfx, "_frame_start"}, 32'(frameStart), 32'd0);
    checkOutput({pfx, "_hs"}, 32'(vgaHs), 32'd1);
    checkOutput({pfx, "_vs"}, 32'(vgaVs), 32'd1);
    checkOutput({pfx, "_rgb"}, 32'({vgaR, vgaG, vgaB}), 32'd0);
  endtask

  // Called on the negedge where rst is released; walks nTicks pixel ticks checking every output.
  task automatic runTicks(input int nTicks, input bit alignMode);
    int relCycle, gap, p, h, v, p1;
    logic [11:0] expRgb, nowRgb;
    logic expHs, expVs, expAct;
    relCycle = cycleCount;
    expRgb = 12'h000;
    expHs = 1'b1;
    expVs = 1'b1;
    for (int k = 1; k <= nTicks; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (pixEn !== 1'b1 && gap < 2 * DIV);
      if (pixEn !== 1'b1) begin
        checkOutput("pix_en_wait", 32'(pixEn), 32'd1);
        return;
      end
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      expAct = (h < HA) && (v < VA);
      checkOutput("pix_gap", 32'(gap), 32'(DIV));
      checkOutput("tick_time", 32'(cycleCount - relCycle), 32'(DIV * k));
      checkOutput("col", 32'(col), 32'(h));
      checkOutput("row", 32'(row), 32'(v));
      checkOutput("active", 32'(active), 32'(expAct));
      checkOutput("frame_start", 32'(frameStart), 32'((p % FRAME) == FRAME - 1));
      checkOutput("vga_hs", 32'(vgaHs), 32'(expHs));
      checkOutput("vga_vs", 32'(vgaVs), 32'(expVs));
      checkOutput("vga_rgb", 32'({vgaR, vgaG, vgaB}), 32'(expRgb));
      p1 = DIV * k - 1;
      checkOutput("div1_pix_en", 32'(pixEn1), 32'd1);
      checkOutput("div1_col", 32'(col1), 32'(p1 % HT));
      checkOutput("div1_frame_start", 32'(frameStart1), 32'((p1 % FRAME) == FRAME - 1));
      applyStimulus(p, alignMode);
      nowRgb = rgbIn;
      expRgb = expAct ? nowRgb : 12'h000;
      expHs = !((h >= HA + HF) && (h < HA + HF + HS));
      expVs = !((v >= VA + VF) && (v < VA + VF + VS));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    // White first frame, then col/row tags; ends mid-line at col 5, row 2 of the second frame.
    runTicks(FRAME + 2 * HT + 6, 1'b0);
    checkOutput("pre_reset_col", 32'(col), 32'd5);
    checkOutput("pre_reset_row", 32'(row), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("async_reset");
    repeat (3) @(negedge clk);
    checkResetValues("reset_hold");
    rst = 1'b1;
    runTicks(FRAME + 5, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
